serial_subtractor: RTL and testbench

//  Bit-serial WIDTH-bit subtractor computing diff = a - b, LSB first, one bit per clock.

---
 rtl/serial_subtractor_pkg.sv | 4 +
 rtl/serial_subtractor_full_subtractor.sv | 11 +
 rtl/serial_subtractor.sv | 90 +++++++++
 tb/tb_serial_subtractor.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg: FSM state codes shared by the serial arithmetic blocks
package serial_subtractor_pkg;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;
endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// full_subtractor: 1-bit full subtractor cell (a, b, bin -> d = a-b-bin, bout)
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: LSB-first bit-serial a-b (clk, rst, start, a, b -> busy, done, diff, bout, ovf)
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sr_q, sr_d, diff_q, diff_d, sr_n;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             brw_q, brw_d, bout_q, bout_d, ovf_q, ovf_d, d, bo, last;
  full_subtractor u_fs (.a(a_q[0]), .b(b_q[0]), .bin(brw_q), .d(d), .bout(bo));
  assign sr_n = {d, sr_q[WIDTH-1:1]};
  assign last = cnt_q == CW'(WIDTH - 1);
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    brw_d   = brw_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    if (state_q == S_IDLE) begin
      if (start) begin
        a_d     = a;
        b_d     = b;
        sr_d    = '0;
        cnt_d   = '0;
        brw_d   = 1'b0;
        state_d = S_RUN;
      end
    end else if (state_q == S_RUN) begin
      a_d   = a_q >> 1;
      b_d   = b_q >> 1;
      sr_d  = sr_n;
      brw_d = bo;
      cnt_d = cnt_q + CW'(1);
      if (last) begin
        diff_d  = sr_n;
        bout_d  = bo;
        // on the last bit a_q[0]/b_q[0] are the operand sign bits and d is the result sign
        ovf_d   = (a_q[0] ^ b_q[0]) & (d ^ a_q[0]);
        state_d = S_DONE;
      end
    end else begin
      state_d = S_IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sr_q    <= '0;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      brw_q   <= brw_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end
  assign busy = state_q == S_RUN;
  assign done = state_q == S_DONE;
  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: self-checking bench for serial_subtractor with a reference model
module tb_serial_subtractor;
  logic       clk = 1'b0;
  logic       rst, start, busy, done, bout, ovf;
  logic [7:0] a, b, diff;
  int         checks = 0;
  int         passed = 0;
  serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .bout(bout), .ovf(ovf)
  );
  always #5 clk = ~clk;
  function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y);
    int s;
    s = int'($signed(x)) - int'($signed(y));
    return {x < y, (s > 127 || s < -128), 8'(x - y)};
  endfunction
  task automatic start_op(input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    start = 1'b1;
    a = x;
    b = y;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_done(output int n, output bit bok);
    n = 0;
    bok = 1'b1;
    while (!done && n < 40) begin
      if (!busy) bok = 1'b0;
      @(negedge clk);
      n++;
    end
  endtask
  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, diff, bout, ovf} !== 12'h0)
      $display("FAIL reset: got busy=%b done=%b diff=%h bout=%b ovf=%b want all 0", busy, done, diff, bout, ovf);
    else passed++;
    rst = 1'b0;
  endtask
  task automatic test_basic;
    int n;
    bit bok;
    start_op(8'd100, 8'd37);
    wait_done(n, bok);
    checks++;
    if (n !== 8 || !bok) $display("FAIL basic_latency: got %0d busy_ok=%b want 8 busy_ok=1", n, bok);
    else passed++;
    checks++;
    if ({diff, bout, ovf} !== {8'h3F, 1'b0, 1'b0})
      $display("FAIL basic_result: got %h/%b/%b want 3f/0/0", diff, bout, ovf);
    else passed++;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) $display("FAIL basic_pulse: got done=%b busy=%b want 0 0", done, busy);
    else passed++;
  endtask
  task automatic test_corners;
    logic [7:0] ta [5] = '{8'd100, 8'd5, 8'hA5, 8'h80, 8'h7F};
    logic [7:0] tb [5] = '{8'd37, 8'd10, 8'hA5, 8'h01, 8'hFF};
    logic [9:0] te [5] = '{{2'b00, 8'h3F}, {2'b10, 8'hFB}, {2'b00, 8'h00}, {2'b01, 8'h7F}, {2'b11, 8'h80}};
    int n;
    bit bok;
    for (int i = 0; i < 5; i++) begin
      start_op(ta[i], tb[i]);
      wait_done(n, bok);
      checks++;
      if ({bout, ovf, diff} !== te[i] || n !== 8)
        $display("FAIL corner%0d: got diff=%h bout=%b ovf=%b lat=%0d want diff=%h bout=%b ovf=%b lat=8",
                 i, diff, bout, ovf, n, te[i][7:0], te[i][9], te[i][8]);
      else passed++;
      @(negedge clk);
    end
  endtask
  task automatic test_back_to_back;
    int t1 = -1, t2 = -1;
    logic [7:0] r1 = '0, r2 = '0;
    @(negedge clk);
    start = 1'b1;
    a = 8'd100;
    b = 8'd37;
    for (int t = 1; t <= 30; t++) begin
      @(negedge clk);
      a = 8'hFF;
      b = 8'h00;
      if (done) begin
        if (t1 < 0) begin t1 = t; r1 = diff; end
        else if (t2 < 0) begin t2 = t; r2 = diff; end
      end
    end
    start = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (t1 !== 9 || r1 !== 8'h3F) $display("FAIL b2b_first: got t=%0d diff=%h want t=9 diff=3f", t1, r1);
    else passed++;
    checks++;
    if (t2 - t1 !== 10 || r2 !== 8'hFF) $display("FAIL b2b_second: got spacing=%0d diff=%h want 10 ff", t2 - t1, r2);
    else passed++;
  endtask
  task automatic test_reset_mid_run;
    int n;
    bit bok;
    bit seen = 1'b0;
    start_op(8'd100, 8'd37);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy, done, diff, bout, ovf} !== 12'h0)
      $display("FAIL mid_reset: got busy=%b done=%b diff=%h bout=%b ovf=%b want all 0", busy, done, diff, bout, ovf);
    else passed++;
    repeat (12) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) $display("FAIL mid_reset_nodone: got done pulse want none");
    else passed++;
    start_op(8'd3, 8'd1);
    wait_done(n, bok);
    checks++;
    if (diff !== 8'h02 || n !== 8) $display("FAIL post_reset_op: got diff=%h lat=%0d want 02 8", diff, n);
    else passed++;
    @(negedge clk);
  endtask
  task automatic test_random;
    int n;
    bit bok;
    logic [7:0] x, y;
    logic [9:0] e;
    for (int i = 0; i < 1000; i++) begin
      x = 8'($urandom);
      y = 8'($urandom);
      e = model(x, y);
      start_op(x, y);
      wait_done(n, bok);
      checks++;
      if (n !== 8 || !bok || busy !== 1'b0)
        $display("FAIL rnd_timing%0d: got lat=%0d busy_ok=%b busy=%b want 8 1 0", i, n, bok, busy);
      else passed++;
      checks++;
      if ({bout, ovf, diff} !== e)
        $display("FAIL rnd_result%0d a=%h b=%h: got diff=%h bout=%b ovf=%b want diff=%h bout=%b ovf=%b",
                 i, x, y, diff, bout, ovf, e[7:0], e[9], e[8]);
      else passed++;
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) $display("FAIL rnd_pulse%0d: got done=%b busy=%b want 0 0", i, done, busy);
      else passed++;
    end
  endtask
  initial begin
    test_reset;
    test_basic;
    test_corners;
    test_back_to_back;
    test_reset_mid_run;
    test_random;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
